sdp_cmd_queue: RTL and testbench
================================

// Module: sdp_cmd_queue
// PURPOSE
// - Host-facing command front end for the SDP driver: buffers get/put commands, issues them one at a time, returns completions.
// - Commands are {opcode, storage_addr, memory_addr, len}.
// - Issues each command to cl_sdp_driver via a start/done pulse pair.
// - Returns one completion per command, carrying a tag, a status and a cycle count.
// - Sits between the host register/mailbox logic and cl_sdp_driver.
// PARAMETERS
// AXI_ADDR_WIDTH  64  width of storage/memory addresses
// C_LENGTH_WIDTH  32  width of file length field
// DEPTH           4   command FIFO entries; power of 2, >=2
// TAG_WIDTH       8   completion tag width
// PORTS
// clk               in   1    clock
// rst_n             in   1    asynchronous active-low reset
// cmd_valid         in   1    command offered
// cmd_ready         out  1    FIFO can accept (= !full)
// cmd_opcode        in   32   0 = get, nonzero = put
// cmd_storage_addr  in   AXI_ADDR_WIDTH  storage address
// cmd_memory_addr   in   AXI_ADDR_WIDTH  memory address
// cmd_len           in   C_LENGTH_WIDTH  bytes to move
// drv_start         out  1    one-cycle start pulse to driver
// drv_done          in   1    one-cycle done pulse from driver
// drv_command       out  32   opcode to driver
// drv_storage_addr  out  AXI_ADDR_WIDTH  address to driver
// drv_memory_addr   out  AXI_ADDR_WIDTH  address to driver
// drv_file_len      out  C_LENGTH_WIDTH  length to driver
// cpl_valid         out  1    completion available
// cpl_ready         in   1    completion consumed
// cpl_tag           out  TAG_WIDTH  tag of completed command
// cpl_status        out  2    0 = ok, 1 = skipped (zero length)
// cpl_cycles        out  32   cycles from drv_start to drv_done; saturates at 2^32-1
// busy              out  1    FSM not IDLE or FIFO not empty
// q_count           out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
// - Reset: all outputs are 0. Pointers, count, tag counter and FSM clear to IDLE. Reset is honoured mid-command; no completion is produced for an in-flight command.
// - Enqueue on cmd_valid && cmd_ready.
//   - The entry stores its fields plus tag = enq_tag_ctr, which then increments, wrapping modulo 2^TAG_WIDTH.
// - FIFO is registered, with no fall-through.
//   - Pointers wrap modulo DEPTH.
//   - Push and pop in the same cycle leave q_count unchanged.
//   - cmd_ready is low only when q_count == DEPTH.
// - FSM states: IDLE, ISSUE, WAIT, CPL.
// - IDLE:
//   - If the FIFO is not empty, load the head entry into the drv_* and tag registers.
//   - If head len == 0: pop, set status = 1, cycles = 0, go to CPL.
//   - Otherwise go to ISSUE.
// - ISSUE:
//   - drv_start = 1 for exactly one cycle; pop the head; clear the cycle counter; go to WAIT.
// - WAIT:
//   - The cycle counter increments each cycle.
//   - On drv_done: latch the counter into cpl_cycles, status = 0, go to CPL.
//   - drv_* remain stable from the ISSUE cycle through the drv_done cycle.
// - CPL:
//   - cpl_valid = 1; cpl_tag, cpl_status and cpl_cycles are held stable.
//   - On cpl_ready, go to IDLE next cycle.
//   - cpl_valid never drops without cpl_ready.
// - Ordering:
//   - At most one command is outstanding at the driver.
//   - Completions are returned in enqueue order.
//   - Minimum spacing between consecutive drv_start pulses is 4 cycles.
// - drv_done outside WAIT is ignored.
// - Enqueue continues during ISSUE, WAIT and CPL.
// TESTING
// - Reset: drive rst_n low mid-WAIT -> all outputs 0 asynchronously; after release, q_count = 0, cmd_ready = 1, no cpl_valid.
// - Single get:
//   - Stimulus: opcode 0, storage 0x1000, memory 0x2000, len 64; drv_done 10 cycles after start.
//   - Response: one drv_start with those values; cpl_tag = 0, status 0, cpl_cycles = 10.
// - Fill: push 5 commands with DEPTH = 4 and drv_done held off.
//   - Head is issued, leaving 4 queued; then cmd_ready = 0 with q_count = 4.
//   - Releasing drv_done restores cmd_ready the cycle after the next pop.
// - Zero length: push len 0 -> no drv_start; completion with status 1, cycles 0.
// - Back-pressure and order:
//   - Stimulus: tags 0..3 queued; cpl_ready held low for 20 cycles per completion.
//   - Response: cpl_* stable while stalled; tags return 0, 1, 2, 3; no second drv_start before each cpl_ready.
// - Wrap and stray pulses: push 260 commands -> cpl_tag wraps 255 -> 0; a drv_done pulse in IDLE produces no completion.

Source files
------------

// File: rtl/sdp_cmd_queue.sv
// Host-side command queue for the SDP driver: buffers get/put commands, issues
// them one at a time via start/done, and returns a tagged completion per command.
module sdp_cmd_queue #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int C_LENGTH_WIDTH = 32,
    parameter int DEPTH          = 4,
    parameter int TAG_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [31:0]               cmd_opcode,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_storage_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_memory_addr,
    input  logic [C_LENGTH_WIDTH-1:0] cmd_len,
    output logic                      drv_start,
    input  logic                      drv_done,
    output logic [31:0]               drv_command,
    output logic [AXI_ADDR_WIDTH-1:0] drv_storage_addr,
    output logic [AXI_ADDR_WIDTH-1:0] drv_memory_addr,
    output logic [C_LENGTH_WIDTH-1:0] drv_file_len,
    output logic                      cpl_valid,
    input  logic                      cpl_ready,
    output logic [TAG_WIDTH-1:0]      cpl_tag,
    output logic [1:0]                cpl_status,
    output logic [31:0]               cpl_cycles,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_CPL} state_t;

    state_t state;

    logic [31:0]               op_mem  [DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] sa_mem  [DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] ma_mem  [DEPTH];
    logic [C_LENGTH_WIDTH-1:0] len_mem [DEPTH];
    logic [TAG_WIDTH-1:0]      tag_mem [DEPTH];

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic [TAG_WIDTH-1:0] enq_tag_ctr;
    logic                 push;
    logic                 pop;
    logic                 head_zero_len;
    logic [31:0]          cycle_ctr;
    logic [31:0]          cycle_inc;

    assign push          = cmd_valid && cmd_ready;
    assign head_zero_len = (len_mem[rd_ptr] == '0);
    // Zero-length heads retire straight from IDLE; everything else leaves the FIFO in ISSUE.
    assign pop           = (state == ST_ISSUE) ||
                           (state == ST_IDLE && count != '0 && head_zero_len);
    assign cycle_inc     = (cycle_ctr == '1) ? cycle_ctr : cycle_ctr + 32'd1;
    assign q_count       = count;
    assign busy          = (state != ST_IDLE) || (count != '0);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (!push && pop)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= cmd_opcode;
            sa_mem[wr_ptr]  <= cmd_storage_addr;
            ma_mem[wr_ptr]  <= cmd_memory_addr;
            len_mem[wr_ptr] <= cmd_len;
            tag_mem[wr_ptr] <= enq_tag_ctr;
        end
    end

    // cmd_ready is registered from the next occupancy so it stays low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            enq_tag_ctr <= '0;
            cmd_ready   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + PTR_W'(1);
                enq_tag_ctr <= enq_tag_ctr + TAG_WIDTH'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_next;
            cmd_ready <= (count_next != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            drv_start        <= 1'b0;
            drv_command      <= '0;
            drv_storage_addr <= '0;
            drv_memory_addr  <= '0;
            drv_file_len     <= '0;
            cpl_valid        <= 1'b0;
            cpl_tag          <= '0;
            cpl_status       <= '0;
            cpl_cycles       <= '0;
            cycle_ctr        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        drv_command      <= op_mem[rd_ptr];
                        drv_storage_addr <= sa_mem[rd_ptr];
                        drv_memory_addr  <= ma_mem[rd_ptr];
                        drv_file_len     <= len_mem[rd_ptr];
                        cpl_tag          <= tag_mem[rd_ptr];
                        if (head_zero_len) begin
                            cpl_status <= 2'd1;
                            cpl_cycles <= '0;
                            cpl_valid  <= 1'b1;
                            state      <= ST_CPL;
                        end else begin
                            drv_start <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    drv_start <= 1'b0;
                    cycle_ctr <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The done cycle itself counts, so a done one cycle after start reports 1.
                    cycle_ctr <= cycle_inc;
                    if (drv_done) begin
                        cpl_cycles <= cycle_inc;
                        cpl_status <= 2'd0;
                        cpl_valid  <= 1'b1;
                        state      <= ST_CPL;
                    end
                end
                ST_CPL: begin
                    if (cpl_ready) begin
                        cpl_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdp_cmd_queue.sv
// Directed bench for sdp_cmd_queue: a scoreboard of enqueued commands is
// popped and compared as each issue/completion appears at the DUT outputs.
`timescale 1ns/1ps
module tb_sdp_cmd_queue;

    localparam int AW = 64;
    localparam int LW = 32;
    localparam int DEPTH = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_opcode = '0;
    logic [AW-1:0] cmd_storage_addr = '0;
    logic [AW-1:0] cmd_memory_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          drv_start;
    logic          drv_done = 1'b0;
    logic [31:0]   drv_command;
    logic [AW-1:0] drv_storage_addr;
    logic [AW-1:0] drv_memory_addr;
    logic [LW-1:0] drv_file_len;
    logic          cpl_valid;
    logic          cpl_ready = 1'b0;
    logic [TW-1:0] cpl_tag;
    logic [1:0]    cpl_status;
    logic [31:0]   cpl_cycles;
    logic          busy;
    logic [2:0]    q_count;

    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   op;
        logic [AW-1:0] sa;
        logic [AW-1:0] ma;
        logic [LW-1:0] len;
    } exp_t;

    exp_t          sb[$];
    logic [TW-1:0] exp_tag = '0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            start_cnt = 0;
    int            starts_seen = 0;
    int            last_start_cyc = 0;

    sdp_cmd_queue #(
        .AXI_ADDR_WIDTH(AW),
        .C_LENGTH_WIDTH(LW),
        .DEPTH(DEPTH),
        .TAG_WIDTH(TW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_storage_addr(cmd_storage_addr),
        .cmd_memory_addr(cmd_memory_addr),
        .cmd_len(cmd_len),
        .drv_start(drv_start),
        .drv_done(drv_done),
        .drv_command(drv_command),
        .drv_storage_addr(drv_storage_addr),
        .drv_memory_addr(drv_memory_addr),
        .drv_file_len(drv_file_len),
        .cpl_valid(cpl_valid),
        .cpl_ready(cpl_ready),
        .cpl_tag(cpl_tag),
        .cpl_status(cpl_status),
        .cpl_cycles(cpl_cycles),
        .busy(busy),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    // Cycle counter and drv_start pulse counter, sampled just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (drv_start) begin
            start_cnt++;
            last_start_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [255:0] allOutputs();
        return 256'({cmd_ready, drv_start, drv_command, drv_storage_addr, drv_memory_addr,
                     drv_file_len, cpl_valid, cpl_tag, cpl_status, cpl_cycles, busy, q_count});
    endfunction

    task automatic applyStimulus(input logic [31:0] op, input logic [AW-1:0] sa,
                                 input logic [AW-1:0] ma, input logic [LW-1:0] len);
        int n;
        exp_t e;
        n = 0;
        cmd_valid        = 1'b1;
        cmd_opcode       = op;
        cmd_storage_addr = sa;
        cmd_memory_addr  = ma;
        cmd_len          = len;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        checkOutput("enq_ready", cmd_ready, 1);
        if (cmd_ready) begin
            tick();
            e.tag = exp_tag;
            e.op  = op;
            e.sa  = sa;
            e.ma  = ma;
            e.len = len;
            sb.push_back(e);
            exp_tag++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic waitStart();
        int n;
        n = 0;
        while (start_cnt == starts_seen && n < 100) begin
            tick();
            n++;
        end
        checkOutput("start_seen", start_cnt, starts_seen + 1);
        starts_seen++;
    endtask

    // Pops the scoreboard head, plays the driver (done 'delay' cycles after start)
    // and the host (cpl_ready held off for 'stall' cycles).
    task automatic runCommand(input int delay, input int stall);
        exp_t        e;
        int          n;
        logic [31:0] exp_cyc;
        logic [1:0]  exp_st;
        if (sb.size() == 0) begin
            checkOutput("sb_nonempty", 256'(sb.size()), 1);
            return;
        end
        e = sb.pop_front();
        if (e.len == '0) begin
            exp_cyc = 32'd0;
            exp_st  = 2'd1;
            n = 0;
            while (!cpl_valid && n < 100) begin
                tick();
                n++;
            end
            checkOutput("zero_len_no_start", start_cnt, starts_seen);
        end else begin
            exp_cyc = 32'(delay);
            exp_st  = 2'd0;
            waitStart();
            checkOutput("drv_fields", {drv_command, drv_storage_addr, drv_memory_addr, drv_file_len},
                        {e.op, e.sa, e.ma, e.len});
            while (cyc < last_start_cyc + delay)
                tick();
            checkOutput("done_timing", cyc, last_start_cyc + delay);
            checkOutput("drv_stable", {drv_command, drv_storage_addr, drv_memory_addr, drv_file_len},
                        {e.op, e.sa, e.ma, e.len});
            drv_done = 1'b1;
            tick();
            drv_done = 1'b0;
            n = 0;
            while (!cpl_valid && n < 100) begin
                tick();
                n++;
            end
        end
        checkOutput("cpl_valid", cpl_valid, 1);
        checkOutput("cpl_tag", cpl_tag, e.tag);
        checkOutput("cpl_status", cpl_status, exp_st);
        checkOutput("cpl_cycles", cpl_cycles, exp_cyc);
        repeat (stall) begin
            tick();
            checkOutput("cpl_hold", {cpl_valid, cpl_tag, cpl_status, cpl_cycles},
                        {1'b1, e.tag, exp_st, exp_cyc});
        end
        checkOutput("one_outstanding", start_cnt, starts_seen);
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        checkOutput("cpl_drop", cpl_valid, 0);
    endtask

    initial begin
        // Power-on reset
        repeat (3) tick();
        checkOutput("reset_outputs", allOutputs(), 0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset", {cmd_ready, q_count, cpl_valid, busy}, {1'b1, 3'd0, 1'b0, 1'b0});

        // Single get
        applyStimulus(32'd0, 64'h1000, 64'h2000, 32'd64);
        runCommand(10, 0);

        // Reset asserted while a command is in flight
        applyStimulus(32'd1, 64'h3000, 64'h4000, 32'd32);
        waitStart();
        tick();
        tick();
        checkOutput("busy_in_wait", busy, 1);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", allOutputs(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
        exp_tag = '0;
        tick();
        checkOutput("rst_release", {cmd_ready, q_count, cpl_valid}, {1'b1, 3'd0, 1'b0});
        repeat (15) tick();
        checkOutput("no_cpl_after_rst", {cpl_valid, busy}, 2'b00);
        checkOutput("no_restart", start_cnt, starts_seen);

        // Back-pressure and ordering, tags 0..3
        applyStimulus(32'd0,  64'hA000_0000_0000_0010, 64'h10, 32'd16);
        applyStimulus(32'd1,  64'h20, 64'hB000_0000_0000_0020, 32'd128);
        applyStimulus(32'h55, 64'h30, 64'h31, 32'd1);
        applyStimulus(32'd0,  64'hFFFF_FFFF_FFFF_FFF0, 64'h40, 32'd4096);
        runCommand(5, 20);
        runCommand(12, 20);
        runCommand(1, 20);
        runCommand(8, 20);

        // Zero-length command completes without touching the driver
        applyStimulus(32'd1, 64'h50, 64'h60, 32'd0);
        runCommand(0, 3);

        // Fill with the driver held off
        for (int i = 0; i < 5; i++)
            applyStimulus(32'(i), 64'(64'h7000 + i), 64'(64'h8000 + i), 32'(i + 1));
        checkOutput("fill_full", {cmd_ready, q_count}, {1'b0, 3'd4});
        checkOutput("fill_head_issued", start_cnt, starts_seen + 1);
        repeat (5) tick();
        checkOutput("fill_hold", {cmd_ready, q_count}, {1'b0, 3'd4});
        runCommand(30, 0);
        tick();
        checkOutput("ready_before_pop", cmd_ready, 0);
        tick();
        checkOutput("ready_after_pop", {cmd_ready, q_count}, {1'b1, 3'd3});
        for (int i = 0; i < 4; i++)
            runCommand(3 + i, 0);

        // Tag wrap over 260 commands, zero-length entries mixed in
        for (int i = 0; i < 260; i++) begin
            applyStimulus(32'(i), 64'(i * 16), 64'(64'h1_0000 + i), (i % 7 == 3) ? 32'd0 : 32'(i + 1));
            runCommand(1 + (i % 3), 0);
        end

        // Stray drv_done while idle
        tick();
        drv_done = 1'b1;
        tick();
        drv_done = 1'b0;
        repeat (6) tick();
        checkOutput("stray_done", {cpl_valid, busy, q_count}, {1'b0, 1'b0, 3'd0});
        checkOutput("stray_no_start", start_cnt, starts_seen);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
